regfile_sb: RTL and testbench

Parametrised multi-write-port integer register file with a per-register busy scoreboard, for the pipelined core. Two combinational read ports and two write ports: port 0 for single-cycle ALU results, port 1 for long-latency results such as loads and multiply/divide. Each long-latency destination is reserved at issue and released on port-1 writeback, so the issue stage can detect RAW and WAW hazards directly from the read-port ready flags. The block keeps the debug read port used by the board monitor.

---
 rtl/regfile_sb.sv | 107 ++++++++++
 tb/tb_regfile_sb.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/regfile_sb.sv
// Multi-write-port integer register file with a per-register busy scoreboard for long-latency results.
// Optional same-cycle write-to-read forwarding is enabled by defining RF_BYPASS_EN.
module regfile_sb #(
  parameter int XLEN = 32,
  parameter int AW   = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [AW-1:0]   ra1,
  input  logic [AW-1:0]   ra2,
  output logic [XLEN-1:0] rd1,
  output logic [XLEN-1:0] rd2,
  output logic            rdy1,
  output logic            rdy2,
  input  logic            we0,
  input  logic [AW-1:0]   wa0,
  input  logic [XLEN-1:0] wd0,
  input  logic            we1,
  input  logic [AW-1:0]   wa1,
  input  logic [XLEN-1:0] wd1,
  input  logic            rsv_v,
  input  logic [AW-1:0]   rsv_a,
  output logic            rsv_ok,
  output logic [AW:0]     busy_cnt,
  input  logic [AW-1:0]   dbg_sel,
  output logic [XLEN-1:0] dbg_data,
  output logic            dbg_busy
);

  localparam int NREG = 1 << AW;

  // Entry 0 is never written and bit 0 of busy is never set, so x0 reads as zero and always ready.
  logic [XLEN-1:0] mem [NREG];
  logic [NREG-1:0] busy;
  logic [NREG-1:0] busy_nxt;
  logic            set_b;
  logic            clr_b;

  always_comb begin
    rd1  = mem[ra1];
    rd2  = mem[ra2];
    rdy1 = !busy[ra1];
    rdy2 = !busy[ra2];
`ifdef RF_BYPASS_EN
    if (ra1 != '0) begin
      if (we1 && (wa1 == ra1)) begin
        rd1  = wd1;
        rdy1 = 1'b1;
      end else if (we0 && (wa0 == ra1)) begin
        rd1 = wd0;
      end
    end
    if (ra2 != '0) begin
      if (we1 && (wa2_match(wa1, ra2))) begin
        rd2  = wd1;
        rdy2 = 1'b1;
      end else if (we0 && (wa0 == ra2)) begin
        rd2 = wd0;
      end
    end
`endif
  end

`ifdef RF_BYPASS_EN
  function automatic logic wa2_match(input logic [AW-1:0] wa, input logic [AW-1:0] ra);
    return wa == ra;
  endfunction
`endif

  assign dbg_data = mem[dbg_sel];
  assign dbg_busy = busy[dbg_sel];

  assign rsv_ok = rsv_v && ((rsv_a == '0) || !busy[rsv_a]);

  // A set always lands on a clear bit and a clear on a set bit, so each changes the count.
  // Both on the same register is impossible, which lets set win trivially.
  assign set_b = rsv_ok && (rsv_a != '0);
  assign clr_b = we1 && (wa1 != '0) && busy[wa1];

  always_comb begin
    busy_nxt = busy;
    if (clr_b) busy_nxt[wa1] = 1'b0;
    if (set_b) busy_nxt[rsv_a] = 1'b1;
    busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy     <= '0;
      busy_cnt <= '0;
    end else begin
      busy     <= busy_nxt;
      busy_cnt <= busy_cnt + {{AW{1'b0}}, set_b} - {{AW{1'b0}}, clr_b};
    end
  end

  // Port 1 is assigned last so it overrides port 0 on an address conflict.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) mem[i] <= '0;
    end else begin
      if (we0 && (wa0 != '0)) mem[wa0] <= wd0;
      if (we1 && (wa1 != '0)) mem[wa1] <= wd1;
    end
  end

endmodule

// File: tb/tb_regfile_sb.sv
// Randomised and directed scoreboard bench for regfile_sb against a behavioural array model.
module tb_regfile_sb;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  ra1, ra2, wa0, wa1, rsv_a, dbg_sel;
  logic [31:0] rd1, rd2, wd0, wd1, dbg_data;
  logic        rdy1, rdy2, we0, we1, rsv_v, rsv_ok, dbg_busy;
  logic [5:0]  busy_cnt;

  regfile_sb #(.XLEN(32), .AW(5)) dut (
    .clk(clk), .rst(rst),
    .ra1(ra1), .ra2(ra2), .rd1(rd1), .rd2(rd2), .rdy1(rdy1), .rdy2(rdy2),
    .we0(we0), .wa0(wa0), .wd0(wd0),
    .we1(we1), .wa1(wa1), .wd1(wd1),
    .rsv_v(rsv_v), .rsv_a(rsv_a), .rsv_ok(rsv_ok), .busy_cnt(busy_cnt),
    .dbg_sel(dbg_sel), .dbg_data(dbg_data), .dbg_busy(dbg_busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] rd1, rd2, dbg_data;
    logic        rdy1, rdy2, rsv_ok, dbg_busy;
    logic [5:0]  busy_cnt;
  } exp_t;

  exp_t        q[$];
  logic [31:0] m_mem [32];
  bit          m_busy [32];
  int          n_vec = 0;
  int          n_err = 0;
  bit          last_ok;
  bit          hold;
  logic [4:0]  hold_a;

  function automatic logic [31:0] exp_rd(input logic [4:0] a);
    logic [31:0] v;
    v = m_mem[a];
`ifdef RF_BYPASS_EN
    if (a != 0 && we1 && wa1 == a) v = wd1;
    else if (a != 0 && we0 && wa0 == a) v = wd0;
`endif
    return v;
  endfunction

  function automatic logic exp_rdy(input logic [4:0] a);
    logic r;
    r = !m_busy[a];
`ifdef RF_BYPASS_EN
    if (a != 0 && we1 && wa1 == a) r = 1'b1;
`endif
    return r;
  endfunction

  task automatic idle();
    rst = 1'b0; ra1 = 0; ra2 = 0; dbg_sel = 0;
    we0 = 0; wa0 = 0; wd0 = 0; we1 = 0; wa1 = 0; wd1 = 0;
    rsv_v = 0; rsv_a = 0;
  endtask

  task automatic next_cyc();
    @(posedge clk);
    #1;
    idle();
  endtask

  // Expected outputs for the current inputs, then the model advances as the coming edge would.
  task automatic apply();
    exp_t e;
    int   bc;
    if (rst) begin
      for (int i = 0; i < 32; i++) begin
        m_mem[i] = 0;
        m_busy[i] = 0;
      end
    end
    e.rd1 = exp_rd(ra1);   e.rdy1 = exp_rdy(ra1);
    e.rd2 = exp_rd(ra2);   e.rdy2 = exp_rdy(ra2);
    e.rsv_ok = rsv_v && (rsv_a == 0 || !m_busy[rsv_a]);
    bc = 0;
    for (int i = 0; i < 32; i++) if (m_busy[i]) bc++;
    e.busy_cnt = bc[5:0];
    e.dbg_data = m_mem[dbg_sel];
    e.dbg_busy = m_busy[dbg_sel];
    q.push_back(e);
    last_ok = e.rsv_ok;
    if (!rst) begin
      if (we0 && wa0 != 0) m_mem[wa0] = wd0;
      if (we1 && wa1 != 0) m_mem[wa1] = wd1;
      if (we1 && wa1 != 0) m_busy[wa1] = 0;
      if (e.rsv_ok && rsv_a != 0) m_busy[rsv_a] = 1;
    end
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_vec++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, expv);
    end
  endtask

  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk("rd1", rd1, e.rd1);
      chk("rdy1", {31'b0, rdy1}, {31'b0, e.rdy1});
      chk("rd2", rd2, e.rd2);
      chk("rdy2", {31'b0, rdy2}, {31'b0, e.rdy2});
      chk("rsv_ok", {31'b0, rsv_ok}, {31'b0, e.rsv_ok});
      chk("busy_cnt", {26'b0, busy_cnt}, {26'b0, e.busy_cnt});
      chk("dbg_data", dbg_data, e.dbg_data);
      chk("dbg_busy", {31'b0, dbg_busy}, {31'b0, e.dbg_busy});
    end
  end

  function automatic logic [4:0] raddr();
    if ($urandom % 2) return 5'($urandom_range(0, 7));
    return 5'($urandom_range(0, 31));
  endfunction

  initial begin
    int bl[$];
    int w;
    for (int i = 0; i < 32; i++) begin
      m_mem[i] = 0;
      m_busy[i] = 0;
    end
    hold = 0;
    hold_a = 0;
    idle();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    ra1 = 5;
    apply();

    // Write x5 and reserve x9, then an asynchronous reset in the middle of a cycle.
    next_cyc(); we0 = 1; wa0 = 5; wd0 = 32'hDEADBEEF; rsv_v = 1; rsv_a = 9; apply();
    next_cyc(); ra1 = 5; ra2 = 9; dbg_sel = 5; apply();
    next_cyc(); ra1 = 5; ra2 = 9; rst = 1; apply();

    // x0 protection.
    next_cyc(); we0 = 1; wa0 = 0; wd0 = 32'h12345678; ra1 = 0; apply();
    next_cyc(); ra1 = 0; rsv_v = 1; rsv_a = 0; apply();
    next_cyc(); ra1 = 0; apply();

    // Both write ports to x7.
    next_cyc(); we0 = 1; wa0 = 7; wd0 = 32'h1; we1 = 1; wa1 = 7; wd1 = 32'h2; apply();
    next_cyc(); ra1 = 7; apply();

    // Reserve/refuse/release of x10, then release and re-reserve in the same cycle.
    next_cyc(); rsv_v = 1; rsv_a = 10; apply();
    next_cyc(); ra1 = 10; rsv_v = 1; rsv_a = 10; dbg_sel = 10; apply();
    next_cyc(); ra1 = 10; we1 = 1; wa1 = 10; wd1 = 32'hCAFE; apply();
    next_cyc(); ra1 = 10; rsv_v = 1; rsv_a = 10; apply();
    next_cyc(); ra1 = 10; rsv_v = 1; rsv_a = 10; we1 = 1; wa1 = 10; wd1 = 32'hBEEF; apply();
    next_cyc(); ra1 = 10; rsv_v = 1; rsv_a = 10; apply();
    next_cyc(); ra1 = 10; we1 = 1; wa1 = 10; wd1 = 32'h77; apply();

    // Reserve of a free register together with a port-1 write to it: set wins.
    next_cyc(); rsv_v = 1; rsv_a = 12; we1 = 1; wa1 = 12; wd1 = 32'hA5A5; apply();
    next_cyc(); ra1 = 12; dbg_sel = 12; apply();
    next_cyc(); we1 = 1; wa1 = 12; wd1 = 32'h5A5A; ra2 = 12; apply();

    // Same-cycle read of a register being written on port 1 and on port 0.
    next_cyc(); we1 = 1; wa1 = 3; wd1 = 32'h55AA; ra2 = 3; apply();
    next_cyc(); ra2 = 3; we0 = 1; wa0 = 4; wd0 = 32'h99; ra1 = 4; apply();
    next_cyc(); ra1 = 4; apply();

    for (int n = 0; n < 500; n++) begin
      next_cyc();
      ra1 = raddr(); ra2 = raddr(); dbg_sel = raddr();
      we0 = $urandom % 2; wa0 = raddr(); wd0 = $urandom;
      we1 = ($urandom % 3) == 0; wd1 = $urandom;
      bl.delete();
      for (int i = 1; i < 32; i++) if (m_busy[i]) bl.push_back(i);
      if (bl.size() > 0 && ($urandom % 4) != 0) wa1 = 5'(bl[$urandom_range(0, bl.size() - 1)]);
      else wa1 = raddr();
      if (hold) begin
        rsv_v = 1; rsv_a = hold_a;
      end else begin
        rsv_v = $urandom % 2; rsv_a = raddr();
      end
      if ($urandom_range(0, 99) == 0) rst = 1;
      apply();
      hold = rsv_v && !last_ok;
      hold_a = rsv_a;
    end

    w = 0;
    while (q.size() != 0 && w < 10) begin
      @(posedge clk);
      w++;
    end
    if (q.size() != 0) begin
      n_vec++;
      n_err++;
      $display("FAIL drain: %0d entries left, expected 0", q.size());
    end
    @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
